main_mem_burst: RTL and testbench
=================================

// Module: main_mem_burst
// PURPOSE
//   Parametrised, byte-addressed, big-endian main memory model with bursts. Serves the
//   instruction fetch and data paths of the processor; replaces the fixed 32-bit main memory.
//   Adds a proper burst handshake (busy deasserts on completion), read-valid strobe and
//   range/alignment error reporting.
// PARAMETERS
//   DATA_WIDTH     32            beat width in bits; multiple of 8
//   ADDR_WIDTH     32            byte address width
//   MEM_BYTES      1048576       storage size in bytes
//   START_ADDRESS  32'h80020000  byte address mapped to storage byte 0
//   MAX_BEATS      16            largest burst length; acc_size codes above it are errors
// PORTS
//   clk       in   1           clock, all state updates on rising edge
//   reset     in   1           asynchronous, active-high reset
//   enable    in   1           request strobe; sampled only when idle
//   wren      in   1           1 = write burst, 0 = read burst (latched at accept)
//   addr      in   ADDR_WIDTH  burst base byte address (latched at accept)
//   acc_size  in   2           beats: 00=1, 01=4, 10=8, 11=16
//   d_in      in   DATA_WIDTH  write beat data; lowest-address byte in the MSB byte lane
//   d_out     out  DATA_WIDTH  read beat data, registered
//   rd_valid  out  1           d_out holds a valid read beat this cycle
//   busy      out  1           burst in progress; new requests ignored
//   err       out  1           one-cycle pulse: request rejected
// BEHAVIOUR
//   - Reset (async): state=IDLE, beat counter=0, d_out=0, rd_valid=0, busy=0, err=0.
//     Storage is NOT cleared by reset (zero-filled once at time 0). Reset mid-burst aborts
//     the burst; beats already written stay written, remaining beats are dropped.
//   - Let B=DATA_WIDTH/8, N=beat count. Accept at cycle T when state=IDLE and enable=1.
//   - Rejected if addr<START_ADDRESS, addr not B-aligned, N>MAX_BEATS, or
//     (addr-START_ADDRESS)+N*B > MEM_BYTES (computed at ADDR_WIDTH+1 bits, no wrap).
//     Rejected: err=1 at T+1 only, no storage access, busy stays 0, rd_valid stays 0.
//   - Beat k (0..N-1) accesses byte offset off_k=(addr-START_ADDRESS)+k*B.
//   - Write: beat k stores d_in sampled at edge T+k into bytes off_k..off_k+B-1.
//   - Read: beat k appears on d_out with rd_valid=1 during cycle T+k+1 (1-cycle latency);
//     d_out holds its last value when rd_valid=0.
//   - busy=1 during cycles T+1..T+N-1 (registered); N=1 never raises busy.
//     Next request may be accepted at cycle T+N (back-to-back, no dead cycle).
//   - FSM: IDLE -(enable & ok & N>1)-> BURST; IDLE -(enable & ok & N=1)-> IDLE (single);
//     BURST -(last beat issued)-> IDLE; any -(reset)-> IDLE.
//   - enable, addr, acc_size, wren are don't-care while busy=1.
// CONFIGURATION
//   WRAP_BURST_EN defined: bursts wrap within the N*B-aligned block containing addr
//     (critical-word-first cache-line fill): off_k = blk + ((addr_off + k*B) mod N*B),
//     blk = addr_off rounded down to N*B. Range check uses the whole block.
//   WRAP_BURST_EN undefined: incrementing bursts only, as described above.
// TESTING
//   1. Reset, write 1 beat 0xDEADBEEF @0x80020000, read 1 beat -> d_out=0xDEADBEEF at T+1,
//      busy never high, byte @0x80020000 = 0xDE.
//   2. Write 4-beat burst 0x11111111..0x44444444 @0x80020010 -> busy high 3 cycles;
//      4-beat read returns same 4 words on consecutive cycles with rd_valid=1.
//   3. Request @0x8001FFFC, @0x80020002, and 16-beat read @START+MEM_BYTES-32 -> err pulse
//      once each, busy=0, storage unchanged.
//   4. Assert reset during beat 2 of an 8-beat write -> all outputs 0 immediately; beats
//      0-1 present on readback, beats 2-7 still zero.
//   5. Back-to-back: 4-beat read accepted at T+4 after a 4-beat write accepted at T ->
//      write completes, read data from T+5..T+8.
//   6. WRAP_BURST_EN: 4-beat read @0x80020018 -> offsets 0x18,0x1C,0x10,0x14;
//      undefined: 0x18,0x1C,0x20,0x24.

Source files
------------

// File: rtl/main_mem_burst.sv
// main_mem_burst: byte-addressed, big-endian main memory model with single/burst access.
// Optional feature: define WRAP_BURST_EN for wrapping (critical-word-first) bursts.
module main_mem_burst #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    MEM_BYTES     = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 32'h8002_0000,
    parameter int                    MAX_BEATS     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            acc_size,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int B  = DATA_WIDTH / 8;
    localparam int OW = ADDR_WIDTH + 1;
    localparam int IW = $clog2(MEM_BYTES);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [OW-1:0] BEAT_BYTES = OW'(B);
    localparam logic [OW-1:0] MEM_LIMIT  = OW'(MEM_BYTES);

    logic [0:0]    state;
    logic [4:0]    cnt;
    logic [4:0]    beats_q;
    logic          wr_q;
    logic [OW-1:0] blk_q;
    logic [OW-1:0] rel0_q;
    logic [OW-1:0] span_q;

    logic [7:0] mem [MEM_BYTES];

    logic [4:0]            req_beats;
    logic [OW-1:0]         req_off;
    logic [OW-1:0]         req_blk;
    logic [OW-1:0]         req_span;
    logic                  req_ok;
    logic                  accept;
    logic                  do_write;
    logic [OW-1:0]         cur_rel;
    logic [OW-1:0]         cur_off;
    logic [IW-1:0]         cur_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_off_bits;

    // NOTE: every combinational output gets a value on every path (default arm) so no latch is inferred.
    always_comb begin
        case (acc_size)
            2'b01:   req_beats = 5'd4;
            2'b10:   req_beats = 5'd8;
            2'b11:   req_beats = 5'd16;
            default: req_beats = 5'd1;
        endcase
    end

    assign req_off  = {1'b0, addr} - {1'b0, START_ADDRESS};
    assign req_span = OW'(req_beats) * BEAT_BYTES;

`ifdef WRAP_BURST_EN
    // Block base: offset rounded down to the N*B burst footprint.
    always_comb begin
        case (acc_size)
            2'b01:   req_blk = req_off - (req_off % OW'(4 * B));
            2'b10:   req_blk = req_off - (req_off % OW'(8 * B));
            2'b11:   req_blk = req_off - (req_off % OW'(16 * B));
            default: req_blk = req_off;
        endcase
    end
`else
    assign req_blk = req_off;
`endif

    // Range sum is ADDR_WIDTH+1 bits wide, so it cannot wrap past the top of the map.
    assign req_ok = (addr >= START_ADDRESS)
                 && (({1'b0, addr} % BEAT_BYTES) == '0)
                 && (int'(req_beats) <= MAX_BEATS)
                 && ((req_blk + req_span) <= MEM_LIMIT);

    assign accept = (state == S_IDLE) && enable && req_ok;

    // Beat 0 is served straight from the request; later beats from the latched burst.
    always_comb begin
        cur_rel = rel0_q + OW'(cnt) * BEAT_BYTES;
        if (cur_rel >= span_q) begin
            cur_rel = cur_rel - span_q;
        end
        if (state == S_IDLE) begin
            cur_off = req_off;
        end else begin
            cur_off = blk_q + cur_rel;
        end
    end

    assign cur_idx         = cur_off[IW-1:0];
    assign unused_off_bits = ^cur_off[OW-1:IW];

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < B; b++) begin
            rd_word[DATA_WIDTH-1-8*b -: 8] = mem[cur_idx + IW'(b)];
        end
    end

    assign do_write = !reset && ((accept && wren) || ((state == S_BURST) && wr_q));

    // NOTE: storage is deliberately left out of reset; contents survive a reset and only control state clears.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < B; b++) begin
                mem[cur_idx + IW'(b)] <= d_in[DATA_WIDTH-1-8*b -: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            beats_q  <= '0;
            wr_q     <= 1'b0;
            blk_q    <= '0;
            rel0_q   <= '0;
            span_q   <= '0;
            d_out    <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            err      <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        if (!req_ok) begin
                            err <= 1'b1;
                        end else begin
                            wr_q    <= wren;
                            blk_q   <= req_blk;
                            rel0_q  <= req_off - req_blk;
                            span_q  <= req_span;
                            beats_q <= req_beats;
                            if (!wren) begin
                                d_out    <= rd_word;
                                rd_valid <= 1'b1;
                            end
                            if (req_beats != 5'd1) begin
                                state <= S_BURST;
                                busy  <= 1'b1;
                                cnt   <= 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (!wr_q) begin
                        d_out    <= rd_word;
                        rd_valid <= 1'b1;
                    end
                    if (cnt == beats_q - 5'd1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_main_mem_burst.sv
// Directed self-checking bench for main_mem_burst (default parameters).
// Expected data follows WRAP_BURST_EN when the macro is defined for the build.
module tb_main_mem_burst;
    localparam logic [31:0] START = 32'h8002_0000;
    localparam logic [31:0] MEMSZ = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wren;
    logic [31:0] addr;
    logic [1:0]  acc_size;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        rd_valid;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] wdata  [16];
    logic [31:0] exp_rd [16];

    main_mem_burst dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .wren     (wren),
        .addr     (addr),
        .acc_size (acc_size),
        .d_in     (d_in),
        .d_out    (d_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] code_of(input int n);
        case (n)
            4:       return 2'b01;
            8:       return 2'b10;
            16:      return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Ends in cycle T+n, where a back-to-back request may be issued.
    task automatic write_burst(input string tag, input logic [31:0] a, input int n);
        enable = 1'b1; wren = 1'b1; addr = a; acc_size = code_of(n); d_in = wdata[0];
        tick();
        enable = 1'b0;
        for (int k = 1; k < n; k++) begin
            check($sformatf("%s busy beat%0d", tag, k), 32'(busy), 32'd1);
            d_in = wdata[k];
            tick();
        end
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    task automatic read_burst(input string tag, input logic [31:0] a, input int n);
        enable = 1'b1; wren = 1'b0; addr = a; acc_size = code_of(n);
        tick();
        enable = 1'b0;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s rd_valid beat%0d", tag, k), 32'(rd_valid), 32'd1);
            check($sformatf("%s d_out beat%0d", tag, k), d_out, exp_rd[k]);
            check($sformatf("%s busy beat%0d", tag, k), 32'(busy), (k < n - 1) ? 32'd1 : 32'd0);
            tick();
        end
        check({tag, " rd_valid end"}, 32'(rd_valid), 32'd0);
        check({tag, " d_out hold"}, d_out, exp_rd[n-1]);
    endtask

    task automatic reject(input string tag, input logic [31:0] a, input logic [1:0] code,
                          input logic wr, input logic [31:0] data);
        enable = 1'b1; wren = wr; addr = a; acc_size = code; d_in = data;
        tick();
        enable = 1'b0;
        check({tag, " err pulse"}, 32'(err), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
        tick();
        check({tag, " err gone"}, 32'(err), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " rd_valid after"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; wren = 1'b0; addr = START; acc_size = 2'b00; d_in = '0;
        tick();
        tick();
        check("reset d_out", d_out, 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // Single-beat write/read and big-endian byte placement
        wdata[0] = 32'hDEAD_BEEF;
        write_burst("t1 wr", START, 1);
        check("t1 byte0", 32'(dut.mem[0]), 32'h0000_00DE);
        check("t1 byte3", 32'(dut.mem[3]), 32'h0000_00EF);
        exp_rd[0] = 32'hDEAD_BEEF;
        read_burst("t1 rd", START, 1);

        // 4-beat incrementing burst
        wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
        wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
        write_burst("t2 wr", START + 32'h10, 4);
        for (int k = 0; k < 4; k++) exp_rd[k] = wdata[k];
        read_burst("t2 rd", START + 32'h10, 4);

        // Rejected requests leave storage untouched
        reject("t3 below", START - 32'd4, 2'b00, 1'b1, 32'hBAD0_BAD0);
        reject("t3 misalign", START + 32'd2, 2'b00, 1'b1, 32'hBAD0_BAD0);
`ifdef WRAP_BURST_EN
        reject("t3 range", START + MEMSZ, 2'b11, 1'b0, 32'h0);
`else
        reject("t3 range", START + MEMSZ - 32'd32, 2'b11, 1'b0, 32'h0);
`endif
        exp_rd[0] = 32'hDEAD_BEEF;
        read_burst("t3 unchanged", START, 1);
        wdata[0] = 32'hCAFE_F00D;
        write_burst("t3 top wr", START + MEMSZ - 32'd4, 1);
        exp_rd[0] = 32'hCAFE_F00D;
        read_burst("t3 top rd", START + MEMSZ - 32'd4, 1);

        // Reset in the middle of an 8-beat write
        for (int k = 0; k < 8; k++) wdata[k] = 32'h0;
        write_burst("t4 clear", START + 32'h100, 8);
        exp_rd[0] = 32'hDEAD_BEEF;
        read_burst("t4 prime", START, 1);
        enable = 1'b1; wren = 1'b1; addr = START + 32'h100; acc_size = 2'b10; d_in = 32'hA000_0000;
        tick();
        enable = 1'b0; d_in = 32'hA111_1111;
        tick();
        check("t4 busy pre-reset", 32'(busy), 32'd1);
        d_in = 32'hA222_2222;
        reset = 1'b1;
        #1;
        check("t4 reset busy", 32'(busy), 32'd0);
        check("t4 reset d_out", d_out, 32'd0);
        check("t4 reset rd_valid", 32'(rd_valid), 32'd0);
        check("t4 reset err", 32'(err), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        exp_rd[0] = 32'hA000_0000; exp_rd[1] = 32'hA111_1111;
        for (int k = 2; k < 8; k++) exp_rd[k] = 32'h0;
        read_burst("t4 rd", START + 32'h100, 8);

        // Back-to-back: read accepted in the cycle right after the write's last beat
        wdata[0] = 32'h5555_5555; wdata[1] = 32'h6666_6666;
        wdata[2] = 32'h7777_7777; wdata[3] = 32'h8888_8888;
        write_burst("t5 wr", START + 32'h200, 4);
        for (int k = 0; k < 4; k++) exp_rd[k] = wdata[k];
        read_burst("t5 rd", START + 32'h200, 4);

        // Burst starting mid-block
        wdata[0] = 32'hE0E0_E0E0;
        write_burst("t6 wr20", START + 32'h20, 1);
        wdata[0] = 32'hE4E4_E4E4;
        write_burst("t6 wr24", START + 32'h24, 1);
        exp_rd[0] = 32'h3333_3333; exp_rd[1] = 32'h4444_4444;
`ifdef WRAP_BURST_EN
        exp_rd[2] = 32'h1111_1111; exp_rd[3] = 32'h2222_2222;
`else
        exp_rd[2] = 32'hE0E0_E0E0; exp_rd[3] = 32'hE4E4_E4E4;
`endif
        read_burst("t6 rd", START + 32'h18, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
